fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/fifo_wr_arbiter_if.sv | 28 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 24 ++
 rtl/fifo_wr_arbiter.sv | 77 +++++++
 tb/tb_fifo_wr_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam int                WCNT_W   = 16;
  localparam logic [WCNT_W-1:0] WCNT_SAT = 16'hFFFF;

  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
    return (v == WCNT_SAT) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester / FIFO-write bundle; slave side is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8
) ();
  import fifo_arb_pkg::*;
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_last;
  logic [N_REQ-1:0]            req_ready;
  logic                        fifo_full;
  logic                        fifo_wr_en;
  logic [DATA_WIDTH-1:0]       fifo_wr_data;
  logic [IDW-1:0]              grant_id;
  logic                        busy;
  logic [WCNT_W-1:0]           write_count;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, write_count
  );
  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, write_count
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority pick: first set request at or after i_ptr, wrapping modulo N.
module rr_pick #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);
  logic [IDW:0] w_pos;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    o_idx = '0;
    o_any = |i_req;
    w_pos = '0;
    for (int k = N-1; k >= 0; k--) begin
      w_pos = {1'b0, i_ptr} + (IDW+1)'(k);
      if (w_pos >= (IDW+1)'(N)) w_pos = w_pos - (IDW+1)'(N);
      if (i_req[w_pos[IDW-1:0]]) o_idx = w_pos[IDW-1:0];
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input logic            clk,
  input logic            rst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int             IDW       = $clog2(N_REQ);
  localparam int             BCW       = $clog2(MAX_BURST+1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST-1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(N_REQ-1);

  state_t            r_state, w_state_nxt;
  logic [IDW-1:0]    r_rr_ptr, r_grant_id, w_pick_idx;
  logic [BCW-1:0]    r_beat_cnt;
  logic [WCNT_W-1:0] r_write_count;
  logic              w_pick_any, w_busy, w_xfer, w_end;

  rr_pick #(.N(N_REQ)) u_pick (
    .i_req (bus.req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_busy = (r_state == BURST);
  assign w_xfer = w_busy & bus.req_valid[r_grant_id] & ~bus.fifo_full;
  assign w_end  = w_xfer & (bus.req_last[r_grant_id] | (r_beat_cnt == LAST_BEAT));

  always_comb begin
    w_state_nxt   = r_state;
    bus.req_ready = '0;
    case (r_state)
      IDLE:    if (w_pick_any) w_state_nxt = BURST;
      BURST: begin
        bus.req_ready[r_grant_id] = ~bus.fifo_full;
        if (w_end) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.fifo_wr_en   = w_xfer;
  assign bus.fifo_wr_data = bus.req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign bus.grant_id     = r_grant_id;
  assign bus.busy         = w_busy;
  assign bus.write_count  = r_write_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // write_count is reloaded every cycle so it always tracks its own next value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_beat_cnt    <= '0;
      r_write_count <= '0;
    end else begin
      r_write_count <= w_xfer ? sat_inc(r_write_count) : r_write_count;
      if (r_state == IDLE && w_pick_any) begin
        r_grant_id <= w_pick_idx;
        r_beat_cnt <= '0;
      end else if (w_xfer) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_end) r_rr_ptr <= (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter with a per-requester beat scoreboard.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();
  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  beat_t       src_q [N][$];
  beat_t       exp_q [N][$];
  bit          src_en [N];
  logic        full_drv;
  logic [15:0] tb_wc;
  int          total = 0;
  int          bad   = 0;

  logic          o_wr_en, o_busy;
  logic [DW-1:0] o_data;
  logic [N-1:0]  o_ready;
  logic [1:0]    o_grant;

  task automatic push(input int i, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l;
    src_q[i].push_back(b);
    exp_q[i].push_back(b);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = src_en[i] && (src_q[i].size() > 0);
      bus.req_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0].d : '0;
      bus.req_last[i] = (src_q[i].size() > 0) ? src_q[i][0].l : 1'b0;
    end
    bus.fifo_full = full_drv;
  endtask

  // One clock: drive at negedge, observe after settle, score what the next posedge will take.
  task automatic cycle();
    logic [N-1:0] er;
    beat_t e;
    @(negedge clk);
    drive_inputs();
    #1;
    o_wr_en = bus.fifo_wr_en; o_busy = bus.busy; o_data = bus.fifo_wr_data;
    o_ready = bus.req_ready;  o_grant = bus.grant_id;
    total++;
    if (bus.write_count !== tb_wc) begin
      bad++; $display("FAIL write_count: got %h want %h", bus.write_count, tb_wc);
    end
    er = '0;
    if (o_busy && !full_drv) er[o_grant] = 1'b1;
    total++;
    if (o_ready !== er) begin
      bad++; $display("FAIL req_ready: got %b want %b", o_ready, er);
    end
    if (o_wr_en === 1'b1) begin
      total++;
      if (full_drv) begin bad++; $display("FAIL wr_while_full: got wr_en=1 want 0"); end
      total++;
      if (exp_q[o_grant].size() == 0) begin
        bad++; $display("FAIL sb_extra: got beat %h from req %0d want none", o_data, o_grant);
      end else begin
        e = exp_q[o_grant].pop_front();
        if (o_data !== e.d) begin
          bad++; $display("FAIL sb_data req%0d: got %h want %h", o_grant, o_data, e.d);
        end
      end
      tb_wc = (tb_wc == 16'hFFFF) ? tb_wc : tb_wc + 16'd1;
    end
    for (int i = 0; i < N; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) void'(src_q[i].pop_front());
  endtask

  task automatic drain(input int budget);
    int n = 0;
    bit done;
    do begin
      cycle(); n++;
      done = !o_busy;
      for (int i = 0; i < N; i++) if (exp_q[i].size() != 0) done = 0;
    end while (!done && n < budget);
    total++;
    if (!done) begin bad++; $display("FAIL drain_timeout: got busy after %0d cycles want idle", n); end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin src_q[i].delete(); exp_q[i].delete(); src_en[i] = 1; end
    full_drv = 1'b0; tb_wc = '0;
    drive_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    full_drv = 1'b0; tb_wc = '0;
    for (int i = 0; i < N; i++) begin
      src_en[i] = 1;
      bus.req_valid[i] = 1'b1;
      bus.req_last[i]  = 1'b0;
      bus.req_data[i*DW +: DW] = 8'hA0 + 8'(i);
    end
    bus.fifo_full = 1'b0;
    #23;
    total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
    total++; if (bus.fifo_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", bus.fifo_wr_en); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++; if (bus.fifo_wr_data !== 8'hA0) begin bad++; $display("FAIL rst_data: got %h want a0", bus.fifo_wr_data); end
    total++; if (bus.write_count !== 16'h0) begin bad++; $display("FAIL rst_wcount: got %h want 0", bus.write_count); end
    apply_reset();
  endtask

  task automatic test_single();
    for (int k = 0; k < 3; k++) push(0, 8'h10 + 8'(k), k == 2);
    cycle();
    total++; if (o_wr_en !== 1'b0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL single_arb: got wr_en=%b busy=%b want 0 0", o_wr_en, o_busy);
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      total++; if (o_wr_en !== 1'b1 || o_data !== 8'h10 + 8'(k)) begin
        bad++; $display("FAIL single_beat%0d: got wr_en=%b data=%h want 1 %h", k, o_wr_en, o_data, 8'h10 + 8'(k));
      end
    end
    cycle();
    total++; if (o_busy !== 1'b0 || bus.write_count !== 16'd3) begin
      bad++; $display("FAIL single_end: got busy=%b wcount=%0d want 0 3", o_busy, bus.write_count);
    end
    // pointer now 1: requester 1 beats requester 0
    push(0, 8'h20, 1'b1);
    push(1, 8'h30, 1'b1);
    cycle(); cycle();
    total++; if (o_grant !== 2'd1 || o_data !== 8'h30) begin
      bad++; $display("FAIL rr_ptr: got grant=%0d data=%h want 1 30", o_grant, o_data);
    end
    drain(20);
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) push(i, 8'(i*16 + k), 1'b0);
    for (int c = 0; c < 25; c++) begin
      logic eb;
      logic [1:0] eg;
      cycle();
      eb = (c % 5) != 0;
      eg = 2'((c / 5) % 4);
      total++; if (o_busy !== eb || o_wr_en !== eb || (eb && o_grant !== eg)) begin
        bad++; $display("FAIL rr_order c%0d: got busy=%b wr=%b grant=%0d want %b %b %0d", c, o_busy, o_wr_en, o_grant, eb, eb, eg);
      end
    end
    drain(60);
  endtask

  task automatic test_full_stall();
    apply_reset();
    for (int k = 0; k < 4; k++) push(2, 8'h50 + 8'(k), 1'b0);
    cycle();
    cycle();
    total++; if (o_wr_en !== 1'b1 || o_data !== 8'h50) begin
      bad++; $display("FAIL full_beat0: got wr=%b data=%h want 1 50", o_wr_en, o_data);
    end
    full_drv = 1'b1;
    repeat (5) begin
      cycle();
      total++; if (o_wr_en !== 1'b0 || o_ready !== '0 || o_grant !== 2'd2 || o_busy !== 1'b1) begin
        bad++; $display("FAIL full_stall: got wr=%b ready=%b grant=%0d busy=%b want 0 0 2 1", o_wr_en, o_ready, o_grant, o_busy);
      end
    end
    full_drv = 1'b0;
    for (int k = 1; k < 4; k++) begin
      cycle();
      total++; if (o_wr_en !== 1'b1 || o_data !== 8'h50 + 8'(k)) begin
        bad++; $display("FAIL full_resume%0d: got wr=%b data=%h want 1 %h", k, o_wr_en, o_data, 8'h50 + 8'(k));
      end
    end
    cycle();
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL full_end: got busy=%b want 0", o_busy); end
  endtask

  task automatic test_valid_drop();
    for (int k = 0; k < 3; k++) push(3, 8'h80 + 8'(k), k == 2);
    cycle(); cycle();
    total++; if (o_data !== 8'h80 || o_grant !== 2'd3) begin
      bad++; $display("FAIL drop_beat0: got data=%h grant=%0d want 80 3", o_data, o_grant);
    end
    src_en[3] = 0;
    repeat (3) begin
      cycle();
      total++; if (o_busy !== 1'b1 || o_wr_en !== 1'b0 || o_grant !== 2'd3) begin
        bad++; $display("FAIL drop_hold: got busy=%b wr=%b grant=%0d want 1 0 3", o_busy, o_wr_en, o_grant);
      end
    end
    src_en[3] = 1;
    drain(10);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < 4; k++) push(1, 8'h61 + 8'(k), 1'b0);
    cycle(); cycle();
    @(negedge clk);
    drive_inputs();
    #1;
    total++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 8'h62) begin
      bad++; $display("FAIL mid_pre: got wr=%b data=%h want 1 62", bus.fifo_wr_en, bus.fifo_wr_data);
    end
    rst_n = 1'b0;
    #1;
    total++; if (bus.fifo_wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== '0 || bus.write_count !== 16'h0) begin
      bad++; $display("FAIL mid_reset: got wr=%b busy=%b ready=%b wc=%h want 0 0 0 0", bus.fifo_wr_en, bus.busy, bus.req_ready, bus.write_count);
    end
    src_q[1].delete(); exp_q[1].delete(); tb_wc = '0;
    drive_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    push(2, 8'h71, 1'b1);
    push(0, 8'h70, 1'b1);
    cycle(); cycle();
    total++; if (o_grant !== 2'd0 || o_data !== 8'h70) begin
      bad++; $display("FAIL mid_regrant: got grant=%0d data=%h want 0 70", o_grant, o_data);
    end
    drain(10);
  endtask

  task automatic test_saturate();
    @(negedge clk);
    force dut.r_write_count = 16'hFFFE;
    @(negedge clk);
    release dut.r_write_count;
    tb_wc = 16'hFFFE;
    for (int k = 0; k < 3; k++) push(2, 8'h90 + 8'(k), k == 2);
    drain(10);
    total++; if (bus.write_count !== 16'hFFFF) begin
      bad++; $display("FAIL saturate: got %h want ffff", bus.write_count);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_valid_drop();
    test_reset_mid();
    test_saturate();
    for (int i = 0; i < N; i++) begin
      total++;
      if (exp_q[i].size() != 0) begin
        bad++; $display("FAIL sb_missing req%0d: got %0d beats left want 0", i, exp_q[i].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
